// File: rtl/lab3_g29_p3_gate_tester.sv
// Stimulus sequencer for a 2-input gate under test: steps {a,b} through 00..11.
// Each vector is held for a settle time, then y is sampled and compared to TRUTH_TABLE.
module lab3_g29_p3_gate_tester #(
  parameter logic [3:0]  TRUTH_TABLE   = 4'b0001,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic       fail_valid,
  output logic [1:0] first_fail_vec
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [1:0] vec;
  logic [3:0] cnt;
  logic       mismatch;

  always_comb begin
    mismatch = (y != TRUTH_TABLE[vec]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      vec            <= '0;
      cnt            <= '0;
      a              <= 1'b0;
      b              <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= SETTLE;
            vec            <= '0;
            cnt            <= '0;
            a              <= 1'b0;
            b              <= 1'b0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            fail_valid     <= 1'b0;
            first_fail_vec <= '0;
          end
        end
        SETTLE: begin
          if (cnt == LAST_CNT) begin
            state <= SAMPLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        SAMPLE: begin
          if (mismatch) begin
            err_count <= err_count + 3'd1;
            if (!fail_valid) begin
              fail_valid     <= 1'b1;
              first_fail_vec <= vec;
            end
          end
          if (vec != 2'd3) begin
            vec    <= vec + 2'd1;
            {a, b} <= vec + 2'd1;
            state  <= SETTLE;
          end else begin
            // pass must include the mismatch of this final sample
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            {a, b} <= 2'b00;
            pass   <= (err_count == 3'd0) && !mismatch;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
